// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the IFU and the LSU.
// It takes one request at a time and alternates grants when both masters ask.
// Each accepted request is checked for range and alignment. Good requests
// run the memory handshake. Faulting requests are answered locally.
// The granted master then sees a one-cycle registered response pulse.
module mem_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned MEM_WORDS = 2048,
    parameter int unsigned AW        = 11
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [31:0]   ifu_addr,
    output logic          ifu_resp_valid,
    output logic [31:0]   ifu_rdata,
    output logic          ifu_resp_err,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [31:0]   lsu_addr,
    input  logic          lsu_wen,
    input  logic [31:0]   lsu_wdata,
    input  logic [3:0]    lsu_wstrb,
    output logic          lsu_resp_valid,
    output logic [31:0]   lsu_rdata,
    output logic          lsu_resp_err,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_resp_valid,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [31:0] IFU_NOP   = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ERR  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            last_lsu;   // 1 when the LSU held the most recent grant
    logic            sel_lsu;    // master owning the current transaction
    logic [AW-1:0]   addr_q;
    logic            wen_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            grant_ifu;
    logic            grant_lsu;
    logic            accept;
    logic [31:0]     req_addr;
    logic [31:0]     offset;
    logic            fault;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin grant, request ready, range check and next-state logic
    always_comb begin
        state_nxt     = state;
        grant_lsu     = lsu_req_valid & (~ifu_req_valid | ~last_lsu);
        grant_ifu     = ifu_req_valid & ~grant_lsu;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        accept        = 1'b0;
        req_addr      = grant_lsu ? lsu_addr : ifu_addr;
        offset        = req_addr - ADDR_BASE;
        fault         = (offset >= MEM_BYTES) || (req_addr[1:0] != 2'b00);

        case (state)
            IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                accept        = grant_ifu | grant_lsu;
                if (accept) begin
                    state_nxt = fault ? ERR : REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = RESP;
                end
            end
            ERR:     state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch on accept and response data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu <= 1'b1;
            sel_lsu  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                sel_lsu  <= grant_lsu;
                last_lsu <= grant_lsu;
                addr_q   <= offset[AW+1:2];
                wen_q    <= grant_lsu & lsu_wen;
                wdata_q  <= grant_lsu ? lsu_wdata : 32'h0;
                wstrb_q  <= grant_lsu ? lsu_wstrb : 4'h0;
                err_q    <= fault;
                rdata_q  <= (fault && !grant_lsu) ? IFU_NOP : 32'h0;
            end
            if (state == WAIT && mem_resp_valid) begin
                rdata_q <= wen_q ? 32'h0 : mem_rdata;
            end
        end
    end

    // Memory request outputs come from state and latched registers only
    always_comb begin
        mem_req_valid = (state == REQ);
        mem_addr      = addr_q;
        mem_wen       = wen_q;
        mem_wdata     = wdata_q;
        mem_wstrb     = wstrb_q;
    end

    // The response goes only to the owning master, for one RESP cycle
    always_comb begin
        ifu_resp_valid = (state == RESP) && !sel_lsu;
        lsu_resp_valid = (state == RESP) && sel_lsu;
        ifu_rdata      = ifu_resp_valid ? rdata_q : 32'h0;
        lsu_rdata      = lsu_resp_valid ? rdata_q : 32'h0;
        ifu_resp_err   = ifu_resp_valid & err_q;
        lsu_resp_err   = lsu_resp_valid & err_q;
    end

endmodule
